// File: rtl/sram_burst_reader.sv
// Burst read front end for the feature-map SRAM: issues sequential reads, tags in-flight words and
// streams them out through a 3-entry skid FIFO. Optional SRAM_RD_STRIDE_EN adds a per-burst address stride.
module sram_burst_reader #(
  parameter int unsigned WORD_AMOUNT = 50176,
  parameter int unsigned DATA_W      = 73,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef SRAM_RD_STRIDE_EN
  ,
  input  logic [ADDR_W-1:0] stride
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0] WA = WORD_AMOUNT[ADDR_W:0];

  state_t            state_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] addr_q, step_q;
  logic [LEN_W-1:0]  len_q, issued_q, handed_q;
  logic              tag0_q, tag1_q;
  logic [DATA_W-1:0] fifo_q [3];
  logic [DATA_W-1:0] fifo_d [3];
  logic [1:0]        cnt_q, cnt_d;

  logic              pop, room;
  logic [2:0]        occ;
  logic [ADDR_W:0]   sum_w, next_w;
  logic [ADDR_W-1:0] addr_next, step_in;

`ifdef SRAM_RD_STRIDE_EN
  assign step_in = stride;
`else
  assign step_in = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  assign pop  = (cnt_q != 2'd0) && m_ready;
  // FIFO slots plus words already requested from the SRAM must never exceed the FIFO depth
  assign occ  = 3'(cnt_q) + 3'(tag0_q) + 3'(tag1_q);
  assign room = (occ < 3'd3) || ((occ == 3'd3) && pop);

  assign sum_w     = {1'b0, addr_q} + {1'b0, step_q};
  assign next_w    = (sum_w >= WA) ? (sum_w - WA) : sum_w;
  assign addr_next = next_w[ADDR_W-1:0];

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) fifo_d[i] = fifo_q[i];
    cnt_d = cnt_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = fifo_q[2];
      cnt_d     = cnt_q - 2'd1;
    end
    if (tag1_q) begin
      for (int unsigned i = 0; i < 3; i++)
        if (2'(i) == cnt_d) fifo_d[i] = sram_dout;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      step_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      handed_q <= '0;
      tag0_q   <= 1'b0;
      tag1_q   <= 1'b0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      tag0_q <= 1'b0;
      tag1_q <= tag0_q;
      cnt_q  <= cnt_d;
      for (int unsigned i = 0; i < 3; i++) fifo_q[i] <= fifo_d[i];

      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              len_q    <= length;
              step_q   <= step_in;
              addr_q   <= base_addr;
              tag0_q   <= 1'b1;
              issued_q <= LEN_W'(1);
              handed_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= (length == LEN_W'(1)) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (room) begin
            addr_q   <= addr_next;
            tag0_q   <= 1'b1;
            issued_q <= issued_q + LEN_W'(1);
            if (issued_q + LEN_W'(1) == len_q) state_q <= DRAIN;
          end
        end
        default: ;
      endcase

      if (pop && busy_q) begin
        handed_q <= handed_q + LEN_W'(1);
        if (state_q == DRAIN && handed_q + LEN_W'(1) == len_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_addr = addr_q;
  assign sram_we   = 1'b0;
  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = fifo_q[0];

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomized bench for sram_burst_reader: an SRAM array model plus an expected-word list computed
// as (base + i*step) mod depth, checked beat by beat with random backpressure.
module tb_sram_burst_reader;

  localparam int WA = 50176;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy, done, sram_we, m_valid, m_ready;
  logic [15:0] sram_addr;
  logic [72:0] sram_dout, m_data;
`ifdef SRAM_RD_STRIDE_EN
  logic [15:0] stride;
`endif

  logic [72:0] mem [WA];
  int total = 0;
  int bad   = 0;

  sram_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_addr(sram_addr), .sram_we(sram_we),
    .sram_dout(sram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef SRAM_RD_STRIDE_EN
    , .stride(stride)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_dout <= mem[sram_addr];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 80'(busy), 80'(0));
    chk({tag, "_done"}, 80'(done), 80'(0));
    chk({tag, "_valid"}, 80'(m_valid), 80'(0));
    chk({tag, "_data"}, 80'(m_data), 80'(0));
    chk({tag, "_addr"}, 80'(sram_addr), 80'(0));
  endtask

  // rnd: random m_ready; stall: first cycle of a 10-cycle m_ready=0 window (<0 none); poke: start mid-burst
  task automatic run_burst(input int base, input int len, input int step, input bit rnd,
                           input int stall, input bit poke);
    logic [72:0] exp_q [$];
    int n = 0, cyc = 0;
    bit pv = 0, pr = 0;
    logic [72:0] pd = '0;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[int'((longint'(base) + longint'(i) * step) % WA)]);
    @(negedge clk);
    start = 1'b1; base_addr = 16'(base); length = 16'(len);
`ifdef SRAM_RD_STRIDE_EN
    stride = 16'(step);
`endif
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      chk("len0_done", 80'(done), 80'(1));
      chk("len0_busy", 80'(busy), 80'(0));
      chk("len0_valid", 80'(m_valid), 80'(0));
      @(negedge clk);
      chk("len0_done_pulse", 80'(done), 80'(0));
      chk("len0_valid2", 80'(m_valid), 80'(0));
      return;
    end
    chk("busy_set", 80'(busy), 80'(1));
    chk("first_addr", 80'(sram_addr), 80'(base));
    while (n < len && cyc < 2000) begin
      if (poke) begin
        start = (cyc == 4);
        base_addr = 16'd7; length = 16'd3;
      end
      if (stall >= 0 && cyc >= stall && cyc < stall + 10) m_ready = 1'b0;
      else if (rnd) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
      chk("we_zero", 80'(sram_we), 80'(0));
      chk("no_early_done", 80'(done), 80'(0));
      if (pv && !pr) begin
        chk("hold_valid", 80'(m_valid), 80'(1));
        chk("hold_data", 80'(m_data), 80'(pd));
      end
      if (m_valid && m_ready) begin
        chk("beat_data", 80'(m_data), 80'(exp_q[n]));
        if (!rnd && stall < 0) chk("beat_time", 80'(cyc), 80'(n + 2));
        n++;
      end
      pv = m_valid; pr = m_ready; pd = m_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("beat_count", 80'(n), 80'(len));
    chk("done_set", 80'(done), 80'(1));
    chk("busy_clr", 80'(busy), 80'(0));
    chk("valid_clr", 80'(m_valid), 80'(0));
    m_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", 80'(done), 80'(0));
    chk("no_extra_beat", 80'(m_valid), 80'(0));
  endtask

  initial begin
    logic [95:0] r;
    int n;
    for (int i = 0; i < WA; i++) begin
      r = {$urandom, $urandom, $urandom};
      mem[i] = r[72:0];
    end
    mem[100] = 73'h1_2345;
    start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
`ifdef SRAM_RD_STRIDE_EN
    stride = 16'd1;
`endif
    rst = 1'b1;
    #13;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_burst(100, 1, 1, 0, -1, 0);
    run_burst(0, 8, 1, 0, -1, 0);
    run_burst(1000, 16, 1, 1, 5, 0);
    run_burst(50174, 4, 1, 0, -1, 0);
    run_burst(5, 0, 1, 0, -1, 0);
    run_burst(200, 8, 1, 1, -1, 1);

    // reset at beat 3 of 8
    @(negedge clk);
    start = 1'b1; base_addr = 16'd400; length = 16'd8; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      if (m_valid && m_ready) n++;
      @(negedge clk);
    end
    chk("pre_reset_beats", 80'(n), 80'(3));
    #2 rst = 1'b1;
    #1 chk_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_rst");

    run_burst(300, 8, 1, 0, -1, 0);
`ifdef SRAM_RD_STRIDE_EN
    run_burst(50170, 4, 3, 0, -1, 0);
    run_burst(77, 3, 0, 1, -1, 0);
`endif
    for (int k = 0; k < 6; k++)
      run_burst(int'($urandom_range(0, WA - 1)), int'($urandom_range(1, 20)), 1,
                1'($urandom_range(0, 1)), -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
